rom_boot_loader: RTL and testbench

ROM_BOOT_LOADER -- requirements
Module: rom_boot_loader

---
 rtl/rom_boot_loader_pkg.sv | 29 ++
 rtl/rom_boot_loader_byte_packer.sv | 28 ++
 rtl/rom_boot_loader.sv | 141 ++++++++++++++
 tb/tb_rom_boot_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_boot_loader_pkg.sv
// Shared constants for the boot loader: ROM bus shape, write strobes, header width and FSM encoding.
package rom_boot_loader_pkg;

  localparam int ROM_ADDR_W = 32;
  localparam int ROM_DATA_W = 32;
  localparam int ROM_NUM    = 4096;
  localparam int HDR_W      = 16;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic CHIP_ENABLE   = 1'b1;

  localparam logic [ROM_DATA_W-1:0] ZERO_WORD = '0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN0  = 3'd1;
  localparam logic [2:0] S_LEN1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  // Byte address of word idx; 32-bit addition wraps naturally.
  function automatic logic [ROM_ADDR_W-1:0] word_addr(input logic [ROM_ADDR_W-1:0] base,
                                                      input logic [HDR_W-1:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/rom_boot_loader_byte_packer.sv
// Assembles four pushed bytes into a little-endian word; the first byte lands in [7:0].
module rom_boot_loader_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic [31:0] word_nxt,
  output logic [1:0]  cnt,
  output logic        last
);

  // Shifting in from the top leaves byte 0 at the bottom after four pushes.
  assign word_nxt = {data, word[31:8]};
  assign last     = push && (cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      word <= '0;
      cnt  <= '0;
    end else if (push) begin
      word <= word_nxt;
      cnt  <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/rom_boot_loader.sv
// Streams a length-prefixed byte image into the instruction ROM write port while holding the core.
module rom_boot_loader
  import rom_boot_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = ROM_NUM,
  parameter int          TIMEOUT   = 100000
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_start,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte_data,
  output logic                  o_byte_ready,
  output logic                  o_we,
  output logic [ROM_ADDR_W-1:0] o_w_addr,
  output logic [ROM_DATA_W-1:0] o_w_data,
  output logic                  o_cpu_hold,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam logic [31:0] MAX_W   = 32'(MAX_WORDS);
  localparam logic [31:0] TMO_LIM = 32'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [7:0]       len_lo;
  logic [HDR_W-1:0] len_n;
  logic [HDR_W-1:0] idx;
  logic [31:0]      tmo_cnt;

  logic             accept;
  logic             start_ok;
  logic             waiting;
  logic             tmo_hit;
  logic [HDR_W-1:0] hdr_n;

  logic [31:0]      pk_word;
  logic [31:0]      pk_word_nxt;
  logic [1:0]       pk_cnt;
  logic             pk_last;
  logic             pk_clr;

  assign accept   = i_byte_valid && o_byte_ready;
  assign start_ok = i_start && ((state == S_IDLE) || (state == S_ERR));
  assign waiting  = (state == S_LEN0) || (state == S_LEN1) || (state == S_DATA);
  assign tmo_hit  = waiting && !accept && (tmo_cnt >= TMO_LIM);
  assign hdr_n    = {i_byte_data, len_lo};

  // A partial word must never reach the ROM, so any abort flushes the packer.
  assign pk_clr = start_ok || (next_state == S_ERR);

  rom_boot_loader_byte_packer u_packer (
    .clk      (i_Clk),
    .rst      (i_Rst),
    .clr      (pk_clr),
    .push     (accept && (state == S_DATA)),
    .data     (i_byte_data),
    .word     (pk_word),
    .word_nxt (pk_word_nxt),
    .cnt      (pk_cnt),
    .last     (pk_last)
  );

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start_ok) next_state = S_LEN0;
      S_LEN0: begin
        if (tmo_hit)     next_state = S_ERR;
        else if (accept) next_state = S_LEN1;
      end
      S_LEN1: begin
        if (tmo_hit) next_state = S_ERR;
        else if (accept) begin
          if (hdr_n == '0)                  next_state = S_DONE;
          else if ({16'd0, hdr_n} > MAX_W)  next_state = S_ERR;
          else                              next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (tmo_hit)      next_state = S_ERR;
        else if (pk_last) next_state = S_WRITE;
      end
      S_WRITE: next_state = ((idx + 16'd1) == len_n) ? S_DONE : S_DATA;
      S_DONE:  next_state = S_IDLE;
      S_ERR:   if (start_ok) next_state = S_LEN0;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state register.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state        <= S_IDLE;
      len_lo       <= '0;
      len_n        <= '0;
      idx          <= '0;
      tmo_cnt      <= '0;
      o_we         <= WRITE_DISABLE;
      o_w_addr     <= ZERO_WORD;
      o_w_data     <= ZERO_WORD;
      o_byte_ready <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_cpu_hold   <= 1'b1;
    end else begin
      state <= next_state;

      if (state == S_LEN0 && accept) len_lo <= i_byte_data;
      if (state == S_LEN1 && accept) len_n  <= hdr_n;

      if (start_ok)              idx <= '0;
      else if (state == S_WRITE) idx <= idx + 16'd1;

      if (start_ok || accept) tmo_cnt <= '0;
      else if (waiting)       tmo_cnt <= tmo_cnt + 32'd1;

      if (next_state == S_WRITE) begin
        o_we     <= WRITE_ENABLE;
        o_w_addr <= word_addr(BASE_ADDR, idx);
        o_w_data <= pk_word_nxt;
      end else begin
        o_we     <= WRITE_DISABLE;
      end

      o_byte_ready <= (next_state == S_LEN0) || (next_state == S_LEN1) || (next_state == S_DATA);
      o_busy       <= (next_state == S_LEN0) || (next_state == S_LEN1) ||
                      (next_state == S_DATA) || (next_state == S_WRITE);
      o_done       <= (next_state == S_DONE);
      o_cpu_hold   <= !((next_state == S_IDLE) || (next_state == S_DONE));

      if (next_state == S_ERR) o_err <= 1'b1;
      else if (start_ok)       o_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rom_boot_loader.sv
// Randomized self-checking bench for rom_boot_loader against a session-level reference model.
module tb_rom_boot_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 4;
  localparam int          TMO  = 16;

  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_byte_valid = 1'b0;
  logic [7:0]  i_byte_data = 8'h00;
  logic        o_byte_ready;
  logic        o_we;
  logic [31:0] o_w_addr;
  logic [31:0] o_w_data;
  logic        o_cpu_hold;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mon_addr[$];
  logic [31:0] mon_data[$];
  int          done_cnt = 0;
  int          we_rdy_bad = 0;

  rom_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .TIMEOUT(TMO)) dut (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .i_start      (i_start),
    .i_byte_valid (i_byte_valid),
    .i_byte_data  (i_byte_data),
    .o_byte_ready (o_byte_ready),
    .o_we         (o_we),
    .o_w_addr     (o_w_addr),
    .o_w_data     (o_w_data),
    .o_cpu_hold   (o_cpu_hold),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  always #5 i_Clk = ~i_Clk;

  always @(negedge i_Clk) begin
    if (o_we === 1'b1) begin
      mon_addr.push_back(o_w_addr);
      mon_data.push_back(o_w_data);
      if (o_byte_ready !== 1'b0) we_rdy_bad++;
    end
    if (o_done === 1'b1) done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge i_Clk);
    #1;
  endtask

  // Reference: word i of the image is bytes 4i..4i+3, least significant first.
  function automatic logic [31:0] model_word(input logic [7:0] d[$], input int i);
    return 32'(d[4*i]) + (32'(d[4*i+1]) << 8) + (32'(d[4*i+2]) << 16) + (32'(d[4*i+3]) << 24);
  endfunction

  task automatic do_start();
    step();
    i_start = 1'b1;
    @(posedge i_Clk);
    step();
    i_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b_in[$], input bit hold);
    logic [7:0] b[$];
    int idle;
    int budget;
    bit acc;
    b = b_in;
    idle = 0;
    budget = 0;
    while (b.size() > 0 && budget < 400) begin
      step();
      i_byte_valid = hold || (idle >= 3) || ($urandom_range(0, 1) == 1);
      i_byte_data  = i_byte_valid ? b[0] : 8'($urandom);
      acc  = i_byte_valid && (o_byte_ready === 1'b1);
      idle = i_byte_valid ? 0 : idle + 1;
      @(posedge i_Clk);
      if (acc) void'(b.pop_front());
      budget++;
    end
    checks++;
    if (b.size() != 0) begin
      errors++;
      $display("FAIL send_budget: %0d bytes left, want 0", b.size());
    end
  endtask

  task automatic run_session(input int n, input logic [7:0] d[$], input bit hold);
    logic [7:0] b[$];
    int  done0;
    int  exp_words;
    bit  bad_len;
    bad_len   = (n > MAXW);
    exp_words = bad_len ? 0 : n;
    do_start();
    checks++;
    if ({o_byte_ready, o_busy, o_err, o_cpu_hold} !== 4'b1101) begin
      errors++;
      $display("FAIL start_flags: rdy/busy/err/hold=%b want 1101", {o_byte_ready, o_busy, o_err, o_cpu_hold});
    end
    mon_addr.delete();
    mon_data.delete();
    done0 = done_cnt;
    b.push_back(8'(n));
    b.push_back(8'(n >> 8));
    if (!bad_len) foreach (d[k]) b.push_back(d[k]);
    send(b, hold);
    step();
    i_byte_valid = 1'b0;
    if (n == 0) begin
      checks++;
      if ({o_done, o_we} !== 2'b10) begin
        errors++;
        $display("FAIL zero_len_done: done/we=%b want 10", {o_done, o_we});
      end
    end else if (bad_len) begin
      checks++;
      if ({o_err, o_cpu_hold, o_busy, o_byte_ready} !== 4'b1100) begin
        errors++;
        $display("FAIL oversize_err: err/hold/busy/rdy=%b want 1100", {o_err, o_cpu_hold, o_busy, o_byte_ready});
      end
    end else begin
      checks++;
      if ({o_we, o_w_addr, o_w_data} !== {1'b1, BASE + 32'(4 * (n - 1)), model_word(d, n - 1)}) begin
        errors++;
        $display("FAIL last_write_latency: we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                 o_we, o_w_addr, o_w_data, BASE + 32'(4 * (n - 1)), model_word(d, n - 1));
      end
      step();
      checks++;
      if ({o_done, o_we} !== 2'b10) begin
        errors++;
        $display("FAIL done_after_write: done/we=%b want 10", {o_done, o_we});
      end
    end
    step();
    checks++;
    if (bad_len ? ({o_err, o_cpu_hold} !== 2'b11) : ({o_done, o_cpu_hold, o_busy, o_err} !== 4'b0000)) begin
      errors++;
      $display("FAIL session_end: done/hold/busy/err=%b%b%b%b bad_len=%0d", o_done, o_cpu_hold, o_busy, o_err, bad_len);
    end
    checks++;
    if (mon_addr.size() != exp_words) begin
      errors++;
      $display("FAIL write_count: got %0d want %0d", mon_addr.size(), exp_words);
    end else begin
      for (int i = 0; i < exp_words; i++) begin
        checks++;
        if (mon_addr[i] !== BASE + 32'(4 * i) || mon_data[i] !== model_word(d, i)) begin
          errors++;
          $display("FAIL write_%0d: got %h@%h want %h@%h", i, mon_data[i], mon_addr[i],
                   model_word(d, i), BASE + 32'(4 * i));
        end
      end
    end
    checks++;
    if (done_cnt - done0 != (bad_len ? 0 : 1)) begin
      errors++;
      $display("FAIL done_pulses: got %0d want %0d", done_cnt - done0, bad_len ? 0 : 1);
    end
  endtask

  task automatic test_reset();
    i_Rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({o_we, o_byte_ready, o_busy, o_done, o_err, o_cpu_hold} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000001", {o_we, o_byte_ready, o_busy, o_done, o_err, o_cpu_hold});
    end
    checks++;
    if ({o_w_addr, o_w_data} !== 64'd0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h data=%h want 0", o_w_addr, o_w_data);
    end
    i_Rst = 1'b0;
    step();
    checks++;
    if ({o_cpu_hold, o_busy} !== 2'b00) begin
      errors++;
      $display("FAIL hold_release: hold/busy=%b want 00", {o_cpu_hold, o_busy});
    end
  endtask

  task automatic test_idle_ignore();
    mon_addr.delete();
    for (int i = 0; i < 6; i++) begin
      i_byte_valid = 1'b1;
      i_byte_data  = 8'($urandom);
      step();
    end
    i_byte_valid = 1'b0;
    checks++;
    if ({o_byte_ready, o_busy, o_cpu_hold, mon_addr.size() == 0} !== 4'b0001) begin
      errors++;
      $display("FAIL idle_ignore: rdy/busy/hold=%b%b%b writes=%0d want 000 and 0",
               o_byte_ready, o_busy, o_cpu_hold, mon_addr.size());
    end
  endtask

  task automatic test_basic();
    logic [7:0] d[$];
    d = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    run_session(2, d, 1'b0);
  endtask

  task automatic test_zero_len();
    logic [7:0] d[$];
    run_session(0, d, 1'b0);
  endtask

  task automatic test_oversize();
    logic [7:0] d[$];
    run_session(5, d, 1'b0);
    for (int i = 0; i < 8; i++) begin
      i_byte_valid = 1'b1;
      i_byte_data  = 8'($urandom);
      step();
    end
    i_byte_valid = 1'b0;
    checks++;
    if ({o_err, o_cpu_hold, o_byte_ready, mon_addr.size() == 0} !== 4'b1101) begin
      errors++;
      $display("FAIL err_sticky: err/hold/rdy=%b%b%b writes=%0d want 110 and 0",
               o_err, o_cpu_hold, o_byte_ready, mon_addr.size());
    end
  endtask

  task automatic test_timeout();
    logic [7:0] b[$];
    do_start();
    mon_addr.delete();
    mon_data.delete();
    b = '{8'h01, 8'h00, 8'($urandom), 8'($urandom), 8'($urandom)};
    send(b, 1'b0);
    step();
    i_byte_valid = 1'b0;
    repeat (4) step();
    checks++;
    if ({o_err, o_busy} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_early: err/busy=%b want 01", {o_err, o_busy});
    end
    repeat (TMO + 2) step();
    checks++;
    if ({o_err, o_busy, o_byte_ready, o_cpu_hold, mon_addr.size() == 0} !== 5'b10011) begin
      errors++;
      $display("FAIL timeout_err: err/busy/rdy/hold=%b%b%b%b writes=%0d want 1001 and 0",
               o_err, o_busy, o_byte_ready, o_cpu_hold, mon_addr.size());
    end
  endtask

  task automatic test_recover();
    logic [7:0] d[$];
    int n;
    n = $urandom_range(1, MAXW);
    for (int k = 0; k < 4 * n; k++) d.push_back(8'($urandom));
    run_session(n, d, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] d[$];
    int bad0;
    bad0 = we_rdy_bad;
    for (int k = 0; k < 4 * MAXW; k++) d.push_back(8'($urandom));
    run_session(MAXW, d, 1'b1);
    checks++;
    if (we_rdy_bad != bad0) begin
      errors++;
      $display("FAIL ready_in_write: %0d cycles with ready during write, want 0", we_rdy_bad - bad0);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 6; s++) begin
      logic [7:0] d[$];
      int n;
      n = $urandom_range(0, MAXW + 1);
      if (n <= MAXW) for (int k = 0; k < 4 * n; k++) d.push_back(8'($urandom));
      run_session(n, d, bit'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b[$];
    logic [31:0] w0;
    do_start();
    mon_addr.delete();
    mon_data.delete();
    b = '{8'h03, 8'h00};
    for (int k = 0; k < 6; k++) b.push_back(8'($urandom));
    w0 = 32'(b[2]) + (32'(b[3]) << 8) + (32'(b[4]) << 16) + (32'(b[5]) << 24);
    send(b, 1'b0);
    step();
    i_byte_valid = 1'b0;
    i_Rst = 1'b1;
    step();
    checks++;
    if ({o_we, o_byte_ready, o_busy, o_done, o_err, o_cpu_hold} !== 6'b000001 || {o_w_addr, o_w_data} !== 64'd0) begin
      errors++;
      $display("FAIL mid_reset_state: flags=%b addr=%h data=%h want 000001 0 0",
               {o_we, o_byte_ready, o_busy, o_done, o_err, o_cpu_hold}, o_w_addr, o_w_data);
    end
    i_Rst = 1'b0;
    repeat (TMO + 4) step();
    checks++;
    if (mon_addr.size() != 1 || mon_data[0] !== w0 || mon_addr[0] !== BASE) begin
      errors++;
      $display("FAIL mid_reset_rom: writes=%0d first=%h want 1 write of %h@%h", mon_addr.size(),
               mon_data.size() > 0 ? mon_data[0] : 32'h0, w0, BASE);
    end
    checks++;
    if ({o_cpu_hold, o_err, o_busy} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_idle: hold/err/busy=%b want 000", {o_cpu_hold, o_err, o_busy});
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_basic();
    test_zero_len();
    test_oversize();
    test_timeout();
    test_recover();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
